// File: rtl/sync_hs_rx_pkg.sv
// Shared definitions for the 4-phase req/ack handshake pair: defaults, widths,
// and the phase encodings used by both the transmit and receive sides.
package sync_hs_rx_pkg;

  localparam int DW_DEFAULT     = 32;
  localparam int SETTLE_DEFAULT = 2;
  localparam int SETTLE_W       = 3;
  localparam int XFER_W         = 16;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_SETTLE = 2'd1,
    RX_VALID  = 2'd2,
    RX_ACK    = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE     = 2'd0,
    TX_REQ      = 2'd1,
    TX_ACK_HIGH = 2'd2,
    TX_ACK_LOW  = 2'd3
  } tx_state_e;

  // Out-of-range settle values saturate rather than wrap.
  function automatic logic [SETTLE_W-1:0] settle_load(input int settle);
    logic [SETTLE_W-1:0] val;
    if (settle > 7) begin
      val = 3'd7;
    end else if (settle < 0) begin
      val = 3'd0;
    end else begin
      val = SETTLE_W'(settle);
    end
    return val;
  endfunction

endpackage

// File: rtl/sync_hs_settle_cnt.sv
// 3-bit load/decrement counter that spaces request detection from data capture.
module sync_hs_settle_cnt
  import sync_hs_rx_pkg::*;
(
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                dec,
  output logic                zero
);

  logic [SETTLE_W-1:0] cnt_d;
  logic [SETTLE_W-1:0] cnt_q;

  // Load wins over decrement; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 3'd0);

endmodule

// File: rtl/sync_hs_rx.sv
// Receive side of a 4-phase handshake: waits for a settled request, presents the
// captured word downstream, then acknowledges until the source drops its request.
module sync_hs_rx
  import sync_hs_rx_pkg::*;
#(
  parameter int DW     = DW_DEFAULT,
  parameter int SETTLE = SETTLE_DEFAULT
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              req_sync,
  input  logic [DW-1:0]     src_data,
  output logic              ack,
  output logic              dst_valid,
  output logic [DW-1:0]     dst_data,
  input  logic              dst_ready,
  output logic [XFER_W-1:0] xfer_cnt,
  output logic              proto_err
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = settle_load(SETTLE);

  rx_state_e         state_d;
  rx_state_e         state_q;
  logic              ack_d;
  logic              ack_q;
  logic              valid_d;
  logic              valid_q;
  logic [DW-1:0]     data_d;
  logic [DW-1:0]     data_q;
  logic [XFER_W-1:0] xfer_d;
  logic [XFER_W-1:0] xfer_cnt_q;
  logic              err_d;
  logic              err_q;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;

  sync_hs_settle_cnt u_settle_cnt (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .load            (cnt_load),
    .load_val        (SETTLE_LOAD),
    .dec             (cnt_dec),
    .zero            (cnt_zero)
  );

  // Next-state and next-output logic; ack and dst_valid are decoded one cycle
  // ahead so the outputs come straight from flops.
  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    valid_d  = 1'b0;
    data_d   = data_q;
    xfer_d   = xfer_cnt_q;
    err_d    = err_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (req_sync) begin
          state_d  = RX_SETTLE;
          cnt_load = 1'b1;
        end else begin
          state_d  = RX_IDLE;
        end
      end
      RX_SETTLE: begin
        if (!req_sync) begin
          state_d = RX_IDLE;
          err_d   = 1'b1;
        end else if (cnt_zero) begin
          state_d = RX_VALID;
          valid_d = 1'b1;
          data_d  = src_data;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RX_VALID: begin
        // A request withdrawn here is flagged, but the word is still delivered.
        if (!req_sync) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (dst_ready) begin
          state_d = RX_ACK;
          ack_d   = 1'b1;
          xfer_d  = xfer_cnt_q + 16'd1;
        end else begin
          valid_d = 1'b1;
        end
      end
      RX_ACK: begin
        if (req_sync) begin
          ack_d   = 1'b1;
        end else begin
          state_d = RX_IDLE;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q    <= RX_IDLE;
      ack_q      <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      xfer_cnt_q <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      xfer_cnt_q <= xfer_d;
      err_q      <= err_d;
    end
  end

  assign ack       = ack_q;
  assign dst_valid = valid_q;
  assign dst_data  = data_q;
  assign xfer_cnt  = xfer_cnt_q;
  assign proto_err = err_q;

endmodule
